// File: rtl/bcd_counter_chain.sv
// Multi-digit packed-BCD up/down counter with a programmable terminal value.
// Loads are sanitised (bad nibbles zeroed, then saturated to MAX_BCD) so the
// count can never leave the legal range. carry_out is a zero-latency decode
// intended to drive the next stage's en directly when stages are chained.
module bcd_counter_chain #(
  parameter int                   DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]  MAX_BCD = 8'h59
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  carry_out,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic bit bcd_legal(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  localparam bit MAX_LEGAL = bcd_legal(MAX_BCD);

  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_counter_chain: DIGITS must be in 1..8");
    end
    if (!MAX_LEGAL || MAX_BCD == '0) begin : g_bad_max
      $error("bcd_counter_chain: MAX_BCD must be nonzero packed BCD");
    end
  endgenerate

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic [W-1:0] inc_val, dec_val;
  logic [W-1:0] fixed_val, load_val;
  logic         nib_fixed, load_sat;

  assign data_out  = cnt_q;
  assign load_err  = err_q;
  assign at_max    = (cnt_q == MAX_BCD);
  assign at_zero   = (cnt_q == '0);
  assign carry_out = en & ~load & ~clear & ((up & at_max) | (~up & at_zero));

  // Per-digit ripple increment/decrement: a digit steps only when every lower
  // digit is at its roll-over value (9 going up, 0 going down).
  always_comb begin
    logic inc_ripple;
    logic dec_ripple;
    logic [3:0] dig;
    inc_val    = cnt_q;
    dec_val    = cnt_q;
    inc_ripple = 1'b1;
    dec_ripple = 1'b1;
    dig        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (inc_ripple) inc_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      if (dec_ripple) dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      inc_ripple = inc_ripple & (dig == 4'd9);
      dec_ripple = dec_ripple & (dig == 4'd0);
    end
  end

  // Load sanitising: zero illegal nibbles first, then clamp to MAX_BCD.
  // Packed BCD with legal nibbles orders the same as unsigned binary, so a
  // plain magnitude compare is valid once the nibbles are fixed.
  always_comb begin
    fixed_val = data_in;
    nib_fixed = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (data_in[4*i +: 4] > 4'd9) begin
        fixed_val[4*i +: 4] = 4'd0;
        nib_fixed           = 1'b1;
      end
    end
    load_sat = (fixed_val > MAX_BCD);
    load_val = load_sat ? MAX_BCD : fixed_val;
  end

  // Next-state selection: clear > load > count > hold.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
      err_d = nib_fixed | load_sat;
    end else if (en) begin
      if (up) cnt_d = at_max  ? '0      : inc_val;
      else    cnt_d = at_zero ? MAX_BCD : dec_val;
    end
  end

  // Count and load-error registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain: a vector table for single-stage
// behaviour plus hand sequences for reset, a full up-count, a
// seconds/minutes/hours chain and a single-digit instance.
module tb_bcd_counter_chain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main 2-digit stage
  logic       en = 0, up = 0, clear = 0, load = 0;
  logic [7:0] data_in = '0, data_out;
  logic       carry_out, at_max, at_zero, load_err;

  bcd_counter_chain #(.DIGITS(2), .MAX_BCD(8'h59)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .data_in(data_in), .data_out(data_out), .carry_out(carry_out),
    .at_max(at_max), .at_zero(at_zero), .load_err(load_err));

  // Clock chain: seconds -> minutes -> hours
  logic       ch_en = 0, ch_load = 0;
  logic [7:0] s_in = '0, m_in = '0, h_in = '0;
  logic [7:0] s_q, m_q, h_q;
  logic       s_c, m_c, h_c;
  logic       s_mx, s_z, s_e, m_mx, m_z, m_e, h_mx, h_z, h_e;

  bcd_counter_chain #(.DIGITS(2), .MAX_BCD(8'h59)) u_sec (
    .clk(clk), .reset_n(reset_n), .en(ch_en), .up(1'b1), .clear(1'b0), .load(ch_load),
    .data_in(s_in), .data_out(s_q), .carry_out(s_c), .at_max(s_mx), .at_zero(s_z), .load_err(s_e));
  bcd_counter_chain #(.DIGITS(2), .MAX_BCD(8'h59)) u_min (
    .clk(clk), .reset_n(reset_n), .en(s_c), .up(1'b1), .clear(1'b0), .load(ch_load),
    .data_in(m_in), .data_out(m_q), .carry_out(m_c), .at_max(m_mx), .at_zero(m_z), .load_err(m_e));
  bcd_counter_chain #(.DIGITS(2), .MAX_BCD(8'h23)) u_hr (
    .clk(clk), .reset_n(reset_n), .en(m_c), .up(1'b1), .clear(1'b0), .load(ch_load),
    .data_in(h_in), .data_out(h_q), .carry_out(h_c), .at_max(h_mx), .at_zero(h_z), .load_err(h_e));

  // Single-digit decade counter with terminal value 7
  logic       d_en = 0, d_up = 1;
  logic [3:0] d_q;
  logic       d_c, d_mx, d_z, d_e;

  bcd_counter_chain #(.DIGITS(1), .MAX_BCD(4'h7)) u_dec (
    .clk(clk), .reset_n(reset_n), .en(d_en), .up(d_up), .clear(1'b0), .load(1'b0),
    .data_in(4'h0), .data_out(d_q), .carry_out(d_c), .at_max(d_mx), .at_zero(d_z), .load_err(d_e));

  typedef struct {
    logic       clr, ld, en, up;
    logic [7:0] din;
    logic       exp_c;
    logic [7:0] exp_q;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    clear = v.clr; load = v.ld; en = v.en; up = v.up; data_in = v.din;
    #1;
    chk($sformatf("vec%0d carry_out", idx), {31'd0, carry_out}, {31'd0, v.exp_c});
    @(posedge clk); #1;
    chk($sformatf("vec%0d data_out", idx), {24'd0, data_out}, {24'd0, v.exp_q});
    chk($sformatf("vec%0d load_err", idx), {31'd0, load_err}, {31'd0, v.exp_err});
    chk($sformatf("vec%0d at_max", idx), {31'd0, at_max}, {31'd0, v.exp_q == 8'h59});
    chk($sformatf("vec%0d at_zero", idx), {31'd0, at_zero}, {31'd0, v.exp_q == 8'h00});
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    int hc_pulses;
    vec_t v;

    // Reset state
    #2;
    chk("reset data_out", {24'd0, data_out}, 32'h0);
    chk("reset load_err", {31'd0, load_err}, 32'h0);
    chk("reset at_zero", {31'd0, at_zero}, 32'h1);
    @(negedge clk); reset_n = 1'b1;

    //             clr ld en up din    c  q      err
    vecs.push_back('{0, 1, 0, 0, 8'h42, 0, 8'h42, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h7A, 0, 8'h59, 1});
    vecs.push_back('{0, 0, 0, 0, 8'h00, 0, 8'h59, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h65, 0, 8'h59, 1});
    vecs.push_back('{0, 0, 1, 1, 8'h00, 1, 8'h00, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 1, 8'h59, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h58, 0});
    vecs.push_back('{0, 0, 1, 1, 8'h00, 0, 8'h59, 0});
    vecs.push_back('{1, 1, 1, 1, 8'h33, 0, 8'h00, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h59, 0, 8'h59, 0});
    vecs.push_back('{0, 1, 1, 1, 8'h33, 0, 8'h33, 0});
    vecs.push_back('{0, 0, 1, 1, 8'h00, 0, 8'h34, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h09, 0, 8'h09, 0});
    vecs.push_back('{0, 0, 1, 1, 8'h00, 0, 8'h10, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h09, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h01, 0, 8'h01, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h00, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 1, 8'h59, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h58, 0});
    vecs.push_back('{0, 1, 0, 0, 8'hA5, 0, 8'h05, 1});
    vecs.push_back('{1, 0, 0, 0, 8'h00, 0, 8'h00, 0});
    vecs.push_back('{0, 1, 0, 0, 8'hFF, 0, 8'h00, 1});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 1, 8'h59, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h5A, 0, 8'h50, 1});
    vecs.push_back('{0, 1, 1, 0, 8'h49, 0, 8'h49, 0});
    vecs.push_back('{0, 0, 0, 1, 8'h00, 0, 8'h49, 0});
    vecs.push_back('{0, 0, 1, 0, 8'h00, 0, 8'h48, 0});
    vecs.push_back('{0, 1, 0, 0, 8'h60, 0, 8'h59, 1});

    foreach (vecs[i]) step(vecs[i], i);

    // Asynchronous reset mid-count at 37
    v = '{0, 1, 0, 0, 8'h37, 0, 8'h37, 0};
    step(v, 100);
    @(negedge clk); load = 0; en = 1; up = 1;
    @(posedge clk); #1;
    chk("pre-reset count", {24'd0, data_out}, 32'h38);
    reset_n = 1'b0;
    #1;
    chk("async reset data_out", {24'd0, data_out}, 32'h0);
    chk("async reset load_err", {31'd0, load_err}, 32'h0);
    @(negedge clk); en = 0; reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("hold after reset data_out", {24'd0, data_out}, 32'h0);
      chk("hold after reset carry_out", {31'd0, carry_out}, 32'h0);
    end

    // Full up-count 00..59,00,01
    @(negedge clk); en = 1; up = 1;
    for (int k = 0; k < 61; k++) begin
      #1;
      chk("upcount carry_out", {31'd0, carry_out}, {31'd0, (k % 60) == 59});
      @(posedge clk); #1;
      chk("upcount data_out", {24'd0, data_out}, {24'd0, to_bcd((k + 1) % 60)});
      if (data_out[3:0] > 4'd9 || data_out[7:4] > 4'd9) chk("upcount nibble legal", 32'd1, 32'd0);
      @(negedge clk);
    end
    en = 0;

    // Chain: 23:59:58 -> 23:59:59 -> 00:00:00
    @(negedge clk);
    ch_load = 1; s_in = 8'h58; m_in = 8'h59; h_in = 8'h23;
    @(posedge clk); #1;
    chk("chain preload", {8'd0, h_q, m_q, s_q}, 32'h0023_5958);
    @(negedge clk); ch_load = 0; ch_en = 1;
    hc_pulses = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      if (h_c) hc_pulses++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    ch_en = 0;
    #1;
    if (h_c) hc_pulses++;
    chk("chain final time", {8'd0, h_q, m_q, s_q}, 32'h0000_0000);
    chk("chain hours carry pulses", hc_pulses, 32'd1);
    @(posedge clk); #1;
    chk("chain holds", {8'd0, h_q, m_q, s_q}, 32'h0000_0000);

    // Single-digit instance, terminal value 7
    @(negedge clk); d_en = 1; d_up = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("decade carry_out", {31'd0, d_c}, {31'd0, k == 7});
      @(posedge clk); #1;
      chk("decade data_out", {28'd0, d_q}, (k + 1) % 8);
      @(negedge clk);
    end
    d_up = 0;
    #1;
    chk("decade down carry", {31'd0, d_c}, 32'd1);
    @(posedge clk); #1;
    chk("decade down wrap", {28'd0, d_q}, 32'd7);
    @(negedge clk); d_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
